// File: rtl/dma_cmd_fetch.sv
// Pops the two FIFO words of one DMA command, reassembles them and offers the
// command to the DMA engine over a valid/ready handshake.
module dma_cmd_fetch #(
  parameter int P_FIFO_DATA_WIDTH = 56,
  parameter int P_CMD_CNT_WIDTH   = 16
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  output logic                         fifo_rd_en,
  input  logic [P_FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                         fifo_empty_n,
  output logic                         dma_cmd_valid,
  input  logic                         dma_cmd_ready,
  output logic [P_FIFO_DATA_WIDTH-1:0] dma_cmd_data0,
  output logic [P_FIFO_DATA_WIDTH-1:0] dma_cmd_data1,
  output logic                         dma_cmd_busy,
  output logic [P_CMD_CNT_WIDTH-1:0]   dma_cmd_cnt
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0001,
    S_READ_0    = 4'b0010,
    S_READ_1    = 4'b0100,
    S_CMD_VALID = 4'b1000
  } state_t;

  state_t                       state_q, state_d;
  logic                         valid_q, valid_d;
  logic [P_FIFO_DATA_WIDTH-1:0] data0_q, data0_d;
  logic [P_FIFO_DATA_WIDTH-1:0] data1_q, data1_d;
  logic [P_CMD_CNT_WIDTH-1:0]   cnt_q, cnt_d;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    cnt_d      = cnt_q;
    fifo_rd_en = 1'b0;

    if (valid_q && dma_cmd_ready) begin
      cnt_d = cnt_q + 1'b1;
    end

    // empty_n is only looked at when a new pair may start; inside a pair both
    // words are guaranteed present.
    case (state_q)
      S_IDLE: begin
        if (fifo_empty_n) state_d = S_READ_0;
      end
      S_READ_0: begin
        fifo_rd_en = 1'b1;
        data0_d    = fifo_rd_data;
        state_d    = S_READ_1;
      end
      S_READ_1: begin
        fifo_rd_en = 1'b1;
        data1_d    = fifo_rd_data;
        state_d    = S_CMD_VALID;
      end
      S_CMD_VALID: begin
        if (dma_cmd_ready) state_d = fifo_empty_n ? S_READ_0 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered valid tracks the state we are about to enter.
    valid_d = (state_d == S_CMD_VALID);
  end

  assign dma_cmd_valid = valid_q;
  assign dma_cmd_data0 = data0_q;
  assign dma_cmd_data1 = data1_q;
  assign dma_cmd_busy  = (state_q != S_IDLE);
  assign dma_cmd_cnt   = cnt_q;

endmodule

// File: tb/tb_dma_cmd_fetch.sv
// Directed bench for dma_cmd_fetch: a small FWFT FIFO model feeds two DUTs
// (16-bit and 2-bit command counters) sharing the same stimulus.
module tb_dma_cmd_fetch;

  localparam int DW = 56;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          rd_en, rd_en2;
  logic [DW-1:0] rd_data;
  logic          empty_n;
  logic          valid, valid2;
  logic [DW-1:0] d0, d1, d0_2, d1_2;
  logic          busy, busy2;
  logic [15:0]   cnt;
  logic [1:0]    cnt2;

  int total = 0;
  int bad   = 0;

  // FIFO model: words written by the stimulus, popped by the DUT, flushed on reset.
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_en_total = 0;

  assign rd_data = mem[rd_ptr[5:0]];
  assign empty_n = ((wr_ptr - rd_ptr) >= 2);

  always @(posedge clk) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (rd_en) rd_ptr <= rd_ptr + 1;
  end

  always @(posedge clk) begin
    if (!rst && rd_en) rd_en_total <= rd_en_total + 1;
  end

  always #5 clk = ~clk;

  dma_cmd_fetch #(.P_FIFO_DATA_WIDTH(DW), .P_CMD_CNT_WIDTH(16)) u_dut (
    .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en), .fifo_rd_data(rd_data),
    .fifo_empty_n(empty_n), .dma_cmd_valid(valid), .dma_cmd_ready(ready),
    .dma_cmd_data0(d0), .dma_cmd_data1(d1), .dma_cmd_busy(busy), .dma_cmd_cnt(cnt)
  );

  dma_cmd_fetch #(.P_FIFO_DATA_WIDTH(DW), .P_CMD_CNT_WIDTH(2)) u_dut_w2 (
    .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en2), .fifo_rd_data(rd_data),
    .fifo_empty_n(empty_n), .dma_cmd_valid(valid2), .dma_cmd_ready(ready),
    .dma_cmd_data0(d0_2), .dma_cmd_data1(d1_2), .dma_cmd_busy(busy2), .dma_cmd_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    int rd_base;
    int cmd_idx;
    logic exp_valid, exp_rd_en;

    rst   = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    $display("reset: valid=%0b busy=%0b cnt=%0d", valid, busy, cnt);
    chk("reset_valid", {63'd0, valid}, 64'd0);
    chk("reset_busy",  {63'd0, busy},  64'd0);
    chk("reset_rd_en", {63'd0, rd_en}, 64'd0);
    chk("reset_data0", {8'd0, d0}, 64'd0);
    chk("reset_data1", {8'd0, d1}, 64'd0);
    chk("reset_cnt",   {48'd0, cnt}, 64'd0);

    // 1: idle with empty FIFO
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_rd_en", {63'd0, rd_en}, 64'd0);
      chk("idle_valid", {63'd0, valid}, 64'd0);
    end
    chk("idle_cnt", {48'd0, cnt}, 64'd0);
    $display("idle: 20 cycles, cnt=%0d", cnt);

    // 2: single command, latency T+3
    ready = 1'b1;
    push(56'h11);
    push(56'h22);
    chk("single_T0_rd_en", {63'd0, rd_en}, 64'd0);
    tick();
    chk("single_T1_rd_en", {63'd0, rd_en}, 64'd1);
    chk("single_T1_busy",  {63'd0, busy},  64'd1);
    chk("single_T1_valid", {63'd0, valid}, 64'd0);
    tick();
    chk("single_T2_rd_en", {63'd0, rd_en}, 64'd1);
    chk("single_T2_data0", {8'd0, d0}, 64'h11);
    tick();
    chk("single_T3_valid", {63'd0, valid}, 64'd1);
    chk("single_T3_rd_en", {63'd0, rd_en}, 64'd0);
    chk("single_T3_data0", {8'd0, d0}, 64'h11);
    chk("single_T3_data1", {8'd0, d1}, 64'h22);
    tick();
    chk("single_done_valid", {63'd0, valid}, 64'd0);
    chk("single_done_busy",  {63'd0, busy},  64'd0);
    chk("single_done_cnt",   {48'd0, cnt}, 64'd1);
    $display("single: data0=%0h data1=%0h cnt=%0d", d0, d1, cnt);

    // 3: backpressure
    ready = 1'b0;
    push(56'h33);
    push(56'h44);
    tick();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {63'd0, valid}, 64'd1);
      chk("bp_rd_en", {63'd0, rd_en}, 64'd0);
      chk("bp_data0", {8'd0, d0}, 64'h33);
      chk("bp_data1", {8'd0, d1}, 64'h44);
      tick();
    end
    ready = 1'b1;
    tick();
    chk("bp_cnt", {48'd0, cnt}, 64'd2);
    chk("bp_valid_drop", {63'd0, valid}, 64'd0);
    tick();
    tick();
    chk("bp_cnt_hold", {48'd0, cnt}, 64'd2);
    $display("backpressure: cnt=%0d", cnt);

    // 4: four commands back-to-back
    rd_base = rd_en_total;
    for (int i = 0; i < 4; i++) begin
      push(56'h100 + 56'(2 * i));
      push(56'h101 + 56'(2 * i));
    end
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_valid = ((k % 3) == 0) && (k <= 12);
      exp_rd_en = ((k % 3) != 0) && (k < 12);
      chk("b2b_valid", {63'd0, valid}, {63'd0, exp_valid});
      chk("b2b_rd_en", {63'd0, rd_en}, {63'd0, exp_rd_en});
      if (exp_valid) begin
        cmd_idx = k / 3 - 1;
        chk("b2b_data0", {8'd0, d0}, 64'h100 + 64'(2 * cmd_idx));
        chk("b2b_data1", {8'd0, d1}, 64'h101 + 64'(2 * cmd_idx));
      end
    end
    chk("b2b_rd_en_total", 64'(rd_en_total - rd_base), 64'd8);
    chk("b2b_cnt", {48'd0, cnt}, 64'd6);
    $display("back_to_back: rd_en pulses=%0d cnt=%0d", rd_en_total - rd_base, cnt);

    // 5: reset during S_READ_1
    push(56'h55);
    push(56'h66);
    tick();
    tick();
    chk("rst_mid_rd_en", {63'd0, rd_en}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", {63'd0, valid}, 64'd0);
    chk("rst_mid_data0", {8'd0, d0}, 64'd0);
    chk("rst_mid_data1", {8'd0, d1}, 64'd0);
    chk("rst_mid_cnt",   {48'd0, cnt}, 64'd0);
    chk("rst_mid_busy",  {63'd0, busy}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_after_valid", {63'd0, valid}, 64'd0);
      chk("rst_after_rd_en", {63'd0, rd_en}, 64'd0);
    end
    $display("reset_mid_fetch: valid=%0b cnt=%0d", valid, cnt);

    // 6: counter wrap on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      push(56'h200 + 56'(i));
      push(56'h300 + 56'(i));
      tick();
      tick();
      tick();
      chk("wrap_valid2", {63'd0, valid2}, 64'd1);
      chk("wrap_data0_2", {8'd0, d0_2}, 64'h200 + 64'(i));
      chk("wrap_data1_2", {8'd0, d1_2}, 64'h300 + 64'(i));
      tick();
      chk("wrap_cnt2", {62'd0, cnt2}, 64'((i + 1) % 4));
      chk("wrap_cnt16", {48'd0, cnt}, 64'(i + 1));
      chk("wrap_idle2", {62'd0, busy2, rd_en2}, 64'd0);
      $display("wrap: handshake %0d cnt2=%0d cnt16=%0d", i + 1, cnt2, cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
